// File: rtl/axi_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_pkg -- AXI4 response and burst codes shared across the memory subsystem
// Revision 1.0
// ----------------------------------------------------------------------------
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sram_array -- word array, one combinational read port, one byte-strobed write port
// Revision 1.0
// ----------------------------------------------------------------------------
module sram_array #(
  parameter int MEM_WORDS = 4096,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [MEM_WORDS];

  // No reset: contents must survive a controller reset.
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/axi_sram_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// axi_sram_slave -- AXI4 INCR-burst memory responder with fixed read/write latency
// Revision 1.0
// ----------------------------------------------------------------------------
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          MEM_WORDS = 4096,
  parameter int          RD_LAT    = 1,
  parameter int          WR_LAT    = 1
) (
  input  logic        clock,
  input  logic        reset,

  output logic        io_slave_awready,
  input  logic        io_slave_awvalid,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,

  output logic        io_slave_wready,
  input  logic        io_slave_wvalid,
  input  logic [31:0] io_slave_wdata,
  input  logic [3:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,

  input  logic        io_slave_bready,
  output logic        io_slave_bvalid,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,

  output logic        io_slave_arready,
  input  logic        io_slave_arvalid,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,

  input  logic        io_slave_rready,
  output logic        io_slave_rvalid,
  output logic [31:0] io_slave_rdata,
  output logic [1:0]  io_slave_rresp,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);

  localparam int          ADDR_W    = $clog2(MEM_WORDS);
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;
  typedef enum logic [1:0] {W_ADDR, W_DATA, W_WAIT, W_RESP} wr_state_t;

  rd_state_t   rd_state;
  logic [31:0] rd_addr;
  logic [7:0]  rd_rem;
  logic [15:0] rd_wait;

  wr_state_t   wr_state;
  logic [31:0] wr_addr;
  logic [7:0]  wr_len;
  logic [8:0]  wr_cnt;
  logic [15:0] wr_wait;
  logic        wr_dec;
  logic        wr_slv;

  function automatic logic [1:0] b_resp(input logic dec, input logic slv);
    if (dec)      return RESP_DECERR;
    else if (slv) return RESP_SLVERR;
    else          return RESP_OKAY;
  endfunction

  // Write port
  logic [31:0] wr_off;
  logic        wr_in_range;
  logic        wr_en;
  logic        wr_dec_final;
  logic        wr_slv_final;

  assign wr_off       = wr_addr - BASE_ADDR;
  assign wr_in_range  = {1'b0, wr_off} < MEM_BYTES;
  assign wr_en        = !reset && (wr_state == W_DATA) && io_slave_wvalid &&
                        io_slave_wready && wr_in_range;
  assign wr_dec_final = wr_dec | !wr_in_range;
  assign wr_slv_final = wr_cnt != {1'b0, wr_len};

  // Address of the beat that will be loaded into the R output registers this cycle
  logic [31:0]       ld_addr;
  logic [31:0]       ld_off;
  logic              ld_in_range;
  logic [ADDR_W-1:0] ld_idx;
  logic [31:0]       mem_rdata;
  logic [31:0]       ld_data;
  logic [1:0]        ld_resp;

  always_comb begin
    ld_addr = rd_addr + 32'd4;
    case (rd_state)
      R_IDLE:  ld_addr = io_slave_araddr;
      R_WAIT:  ld_addr = rd_addr;
      default: ld_addr = rd_addr + 32'd4;
    endcase
  end

  assign ld_off      = ld_addr - BASE_ADDR;
  assign ld_in_range = {1'b0, ld_off} < MEM_BYTES;
  assign ld_idx      = ld_off[ADDR_W+1:2];
  assign ld_resp     = ld_in_range ? RESP_OKAY : RESP_DECERR;

  // Merge a same-edge write so the loaded beat already sees it next cycle.
  always_comb begin
    ld_data = mem_rdata;
    if (wr_en && (wr_off[ADDR_W+1:2] == ld_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (io_slave_wstrb[b]) ld_data[8*b +: 8] = io_slave_wdata[8*b +: 8];
      end
    end
    if (!ld_in_range) ld_data = '0;
  end

  sram_array #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_sram_array (
    .clock (clock),
    .we    (wr_en),
    .waddr (wr_off[ADDR_W+1:2]),
    .wdata (io_slave_wdata),
    .wstrb (io_slave_wstrb),
    .raddr (ld_idx),
    .rdata (mem_rdata)
  );

  // Read channel
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_state         <= R_IDLE;
      rd_addr          <= '0;
      rd_rem           <= '0;
      rd_wait          <= '0;
      io_slave_arready <= 1'b1;
      io_slave_rvalid  <= 1'b0;
      io_slave_rdata   <= '0;
      io_slave_rresp   <= RESP_OKAY;
      io_slave_rlast   <= 1'b0;
      io_slave_rid     <= '0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (io_slave_arvalid && io_slave_arready) begin
            rd_addr          <= io_slave_araddr;
            rd_rem           <= io_slave_arlen;
            rd_wait          <= '0;
            io_slave_rid     <= io_slave_arid;
            io_slave_arready <= 1'b0;
            if (RD_LAT == 0) begin
              rd_state        <= R_DATA;
              io_slave_rvalid <= 1'b1;
              io_slave_rdata  <= ld_data;
              io_slave_rresp  <= ld_resp;
              io_slave_rlast  <= (io_slave_arlen == 8'd0);
            end else begin
              rd_state <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (rd_wait == 16'(RD_LAT - 1)) begin
            rd_state        <= R_DATA;
            io_slave_rvalid <= 1'b1;
            io_slave_rdata  <= ld_data;
            io_slave_rresp  <= ld_resp;
            io_slave_rlast  <= (rd_rem == 8'd0);
          end else begin
            rd_wait <= rd_wait + 16'd1;
          end
        end
        R_DATA: begin
          if (io_slave_rready) begin
            if (rd_rem == 8'd0) begin
              rd_state         <= R_IDLE;
              io_slave_rvalid  <= 1'b0;
              io_slave_rdata   <= '0;
              io_slave_rresp   <= RESP_OKAY;
              io_slave_rlast   <= 1'b0;
              io_slave_arready <= 1'b1;
            end else begin
              rd_addr        <= ld_addr;
              rd_rem         <= rd_rem - 8'd1;
              io_slave_rdata <= ld_data;
              io_slave_rresp <= ld_resp;
              io_slave_rlast <= (rd_rem == 8'd1);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  // Write channel
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state         <= W_ADDR;
      wr_addr          <= '0;
      wr_len           <= '0;
      wr_cnt           <= '0;
      wr_wait          <= '0;
      wr_dec           <= 1'b0;
      wr_slv           <= 1'b0;
      io_slave_awready <= 1'b1;
      io_slave_wready  <= 1'b0;
      io_slave_bvalid  <= 1'b0;
      io_slave_bresp   <= RESP_OKAY;
      io_slave_bid     <= '0;
    end else begin
      case (wr_state)
        W_ADDR: begin
          if (io_slave_awvalid && io_slave_awready) begin
            wr_state         <= W_DATA;
            wr_addr          <= io_slave_awaddr;
            wr_len           <= io_slave_awlen;
            wr_cnt           <= '0;
            wr_dec           <= 1'b0;
            wr_slv           <= 1'b0;
            io_slave_bid     <= io_slave_awid;
            io_slave_awready <= 1'b0;
            io_slave_wready  <= 1'b1;
          end
        end
        W_DATA: begin
          if (io_slave_wvalid && io_slave_wready) begin
            wr_addr <= wr_addr + 32'd4;
            wr_dec  <= wr_dec_final;
            if (wr_cnt != 9'h1FF) wr_cnt <= wr_cnt + 9'd1;
            if (io_slave_wlast) begin
              io_slave_wready <= 1'b0;
              wr_slv          <= wr_slv_final;
              wr_wait         <= '0;
              if (WR_LAT == 0) begin
                wr_state        <= W_RESP;
                io_slave_bvalid <= 1'b1;
                io_slave_bresp  <= b_resp(wr_dec_final, wr_slv_final);
              end else begin
                wr_state <= W_WAIT;
              end
            end
          end
        end
        W_WAIT: begin
          if (wr_wait == 16'(WR_LAT - 1)) begin
            wr_state        <= W_RESP;
            io_slave_bvalid <= 1'b1;
            io_slave_bresp  <= b_resp(wr_dec, wr_slv);
          end else begin
            wr_wait <= wr_wait + 16'd1;
          end
        end
        W_RESP: begin
          if (io_slave_bready) begin
            wr_state         <= W_ADDR;
            io_slave_bvalid  <= 1'b0;
            io_slave_awready <= 1'b1;
          end
        end
        default: wr_state <= W_ADDR;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_axi_sram_slave -- table-driven write/readback plus burst, error and reset sequences
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_axi_sram_slave;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          WORDS  = 4096;
  localparam int          RD_LAT = 1;
  localparam int          WR_LAT = 1;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        awready, awvalid = 0;
  logic [31:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic        wready, wvalid = 0, wlast = 0;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        bready = 0, bvalid;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arready, arvalid = 0;
  logic [31:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic        rready = 0, rvalid, rlast;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;

  axi_sram_slave #(
    .BASE_ADDR (BASE), .MEM_WORDS (WORDS), .RD_LAT (RD_LAT), .WR_LAT (WR_LAT)
  ) dut (
    .clock (clock), .reset (reset),
    .io_slave_awready (awready), .io_slave_awvalid (awvalid), .io_slave_awaddr (awaddr),
    .io_slave_awid (awid), .io_slave_awlen (awlen),
    .io_slave_wready (wready), .io_slave_wvalid (wvalid), .io_slave_wdata (wdata),
    .io_slave_wstrb (wstrb), .io_slave_wlast (wlast),
    .io_slave_bready (bready), .io_slave_bvalid (bvalid), .io_slave_bresp (bresp),
    .io_slave_bid (bid),
    .io_slave_arready (arready), .io_slave_arvalid (arvalid), .io_slave_araddr (araddr),
    .io_slave_arid (arid), .io_slave_arlen (arlen),
    .io_slave_rready (rready), .io_slave_rvalid (rvalid), .io_slave_rdata (rdata),
    .io_slave_rresp (rresp), .io_slave_rlast (rlast), .io_slave_rid (rid)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  rbeat_t      rq[$];
  bexp_t       bq[$];
  logic [31:0] model [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got timeout/unexpected expected handshake", name);
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (33'(a) >= 33'(BASE)) && (33'(a) < 33'(BASE) + 33'(4 * WORDS));
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    logic [31:0] w;
    if (in_range(a)) begin
      idx = int'((a - BASE) >> 2);
      w = model.exists(idx) ? model[idx] : 32'h0;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      model[idx] = w;
    end
  endtask

  task automatic push_model(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
    logic [31:0] ba;
    for (int i = 0; i <= int'(len); i++) begin
      ba = a + 32'(4 * i);
      if (in_range(ba)) rq.push_back('{model[int'((ba - BASE) >> 2)], 2'b00, (i == int'(len)), id});
      else              rq.push_back('{32'h0, 2'b11, (i == int'(len)), id});
    end
  endtask

  // Scoreboard pop on R/B handshakes, plus R hold-stability during stalls
  logic        hold_v = 0;
  logic [31:0] hold_data;
  always @(negedge clock) begin
    rbeat_t er;
    bexp_t  eb;
    if (!reset) begin
      if (hold_v && rvalid) check("r_stall_stable", rdata, hold_data);
      hold_v    = rvalid && !rready;
      hold_data = rdata;
      if (rvalid && rready) begin
        if (rq.size() == 0) fail_now("r_unexpected_beat");
        else begin
          er = rq.pop_front();
          check("rdata", rdata, er.data);
          check("rresp", 32'(rresp), 32'(er.resp));
          check("rlast", 32'(rlast), 32'(er.last));
          check("rid",   32'(rid),   32'(er.id));
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) fail_now("b_unexpected");
        else begin
          eb = bq.pop_front();
          check("bresp", 32'(bresp), 32'(eb.resp));
          check("bid",   32'(bid),   32'(eb.id));
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input int nbeats, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input bit hold_b);
    int n, t;
    bit hs;
    awvalid = 1; awaddr = addr; awid = id; awlen = len;
    n = 0; hs = 0;
    while (!hs && n < 50) begin
      @(negedge clock); hs = awready;
      @(posedge clock); #1; n++;
    end
    awvalid = 0;
    if (!hs) begin fail_now("aw_handshake"); return; end
    t = 0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1; wdata = data + 32'(i); wstrb = strb; wlast = (i == nbeats - 1);
      n = 0; hs = 0;
      while (!hs && n < 50) begin
        @(negedge clock); hs = wready; if (hs) t = cyc;
        @(posedge clock); #1; n++;
      end
      if (!hs) fail_now("w_handshake");
      else model_write(addr + 32'(4 * i), data + 32'(i), strb);
    end
    wvalid = 0; wlast = 0;
    if (!hold_b) bq.push_back('{exp_resp, id});
    bready = !hold_b;
    n = 0; hs = 0;
    while (!hs && n < 50) begin
      @(negedge clock); hs = bvalid;
      if (hs) check("b_latency", 32'(cyc - t), 32'(1 + WR_LAT));
      @(posedge clock); #1; n++;
    end
    bready = 0;
    if (!hs) fail_now("b_timeout");
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [7:0] pat);
    int n, t, k;
    bit hs, done, first, seen;
    arvalid = 1; araddr = addr; arid = id; arlen = len;
    n = 0; hs = 0; t = 0;
    while (!hs && n < 50) begin
      @(negedge clock); hs = arready; if (hs) t = cyc;
      @(posedge clock); #1; n++;
    end
    arvalid = 0;
    if (!hs) begin fail_now("ar_handshake"); return; end
    k = 0; done = 0; first = 1; n = 0;
    while (!done && n < 300) begin
      seen = rvalid;
      if (seen) begin
        if (first) begin check("r_latency", 32'(cyc - t), 32'(1 + RD_LAT)); first = 0; end
        rready = pat[k % 8];
      end else rready = 0;
      @(negedge clock); done = rvalid && rready && rlast;
      @(posedge clock); #1;
      if (seen) k++;
      n++;
    end
    rready = 0;
    if (!done) fail_now("r_timeout");
  endtask

  vec_t vt[9];

  initial begin
    int n;
    bit hs;

    vt[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF};
    vt[1] = '{32'h8000_0010, 32'h00AA_0000, 4'h4, 32'hDEAA_BEEF};
    vt[2] = '{32'h8000_0000, 32'h1111_1111, 4'hF, 32'h1111_1111};
    vt[3] = '{32'h8000_0004, 32'h2222_2222, 4'hF, 32'h2222_2222};
    vt[4] = '{32'h8000_0008, 32'h3333_3333, 4'hF, 32'h3333_3333};
    vt[5] = '{32'h8000_000C, 32'h4444_4444, 4'hF, 32'h4444_4444};
    vt[6] = '{32'h8000_000C, 32'h0000_AB00, 4'h2, 32'h4444_AB44};
    vt[7] = '{32'h8000_3FFC, 32'hA5A5_A5A5, 4'hF, 32'hA5A5_A5A5};
    vt[8] = '{32'h8000_3FFC, 32'h0000_00C3, 4'h1, 32'hA5A5_A5C3};

    repeat (3) @(posedge clock);
    #1;
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_wready",  32'(wready),  32'd0);
    check("rst_bvalid",  32'(bvalid),  32'd0);
    check("rst_rvalid",  32'(rvalid),  32'd0);
    check("rst_rlast",   32'(rlast),   32'd0);
    check("rst_rdata",   rdata,        32'd0);
    check("rst_rresp",   32'(rresp),   32'd0);
    check("rst_bresp",   32'(bresp),   32'd0);
    check("rst_bid",     32'(bid),     32'd0);
    check("rst_rid",     32'(rid),     32'd0);
    reset = 0;
    @(posedge clock); #1;

    // Single-beat write then readback against the table's expected word
    for (int i = 0; i < 9; i++) begin
      axi_write(vt[i].addr, 4'(i), 8'd0, 1, vt[i].wdata, vt[i].strb, 2'b00, 0);
      rq.push_back('{vt[i].exp, 2'b00, 1'b1, 4'(i) ^ 4'hF});
      axi_read(vt[i].addr, 4'(i) ^ 4'hF, 8'd0, 8'hFF);
    end

    // 4-beat burst with rready 1,0,1,1
    push_model(32'h8000_0000, 4'h7, 8'd3);
    axi_read(32'h8000_0000, 4'h7, 8'd3, 8'b1111_1101);

    // Burst running off the end of the array
    push_model(32'h8000_3FFC, 4'h8, 8'd1);
    axi_read(32'h8000_3FFC, 4'h8, 8'd1, 8'hFF);

    // Out-of-range read and write; word 0 must be untouched
    push_model(32'h7FFF_FFFC, 4'h2, 8'd0);
    axi_read(32'h7FFF_FFFC, 4'h2, 8'd0, 8'hFF);
    axi_write(32'h8000_4000, 4'h3, 8'd0, 1, 32'hFFFF_FFFF, 4'hF, 2'b11, 0);
    push_model(32'h8000_0000, 4'h3, 8'd0);
    axi_read(32'h8000_0000, 4'h3, 8'd0, 8'hFF);

    // Short burst -> SLVERR, then immediate new AW
    axi_write(32'h8000_0100, 4'h5, 8'd1, 1, 32'h5555_0001, 4'hF, 2'b10, 0);
    check("awready_after_b", 32'(awready), 32'd1);
    axi_write(32'h8000_0104, 4'h6, 8'd1, 2, 32'h6666_0000, 4'hF, 2'b00, 0);
    push_model(32'h8000_0100, 4'hA, 8'd2);
    axi_read(32'h8000_0100, 4'hA, 8'd2, 8'hFF);

    // Reset while R_DATA stalls and W_RESP waits on bready
    axi_write(32'h8000_0020, 4'h9, 8'd0, 1, 32'h1234_5678, 4'hF, 2'b00, 1);
    check("b_pending", 32'(bvalid), 32'd1);
    arvalid = 1; araddr = 32'h8000_0000; arid = 4'h4; arlen = 8'd3;
    n = 0; hs = 0;
    while (!hs && n < 50) begin
      @(negedge clock); hs = arready;
      @(posedge clock); #1; n++;
    end
    arvalid = 0;
    n = 0;
    while (!rvalid && n < 20) begin @(posedge clock); #1; n++; end
    check("r_data_before_reset", 32'(rvalid), 32'd1);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    check("rr_rvalid",  32'(rvalid),  32'd0);
    check("rr_bvalid",  32'(bvalid),  32'd0);
    check("rr_wready",  32'(wready),  32'd0);
    check("rr_arready", 32'(arready), 32'd1);
    check("rr_awready", 32'(awready), 32'd1);
    check("rr_rlast",   32'(rlast),   32'd0);
    check("rr_rdata",   rdata,        32'd0);
    push_model(32'h8000_0020, 4'h1, 8'd0);
    axi_read(32'h8000_0020, 4'h1, 8'd0, 8'hFF);
    push_model(32'h8000_0010, 4'h2, 8'd0);
    axi_read(32'h8000_0010, 4'h2, 8'd0, 8'hFF);

    repeat (2) @(posedge clock);
    check("rq_drained", 32'(rq.size()), 32'd0);
    check("bq_drained", 32'(bq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
